case_conv_arbiter: RTL and testbench
====================================

// Module: case_conv_arbiter
// PURPOSE
//  Round-robin arbiter sharing one ASCII case-conversion unit among NUM_REQ byte streams.
//  Accepts bytes on per-requester valid/ready ports and grants at most one per cycle.
//  The granted byte passes through the lowercase->uppercase datapath and is registered
//  into a single output stage, tagged with its source index. Sits between text producers
//  and the downstream byte sink.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  CNT_W    16  width of conversion statistics counter
// PORTS
//  clk         in   1            single clock, rising edge
//  rst_n       in   1            asynchronous active-low reset
//  req_valid   in   NUM_REQ      byte offered by requester i
//  req_data    in   8*NUM_REQ    byte of requester i at [8*i+7:8*i]
//  req_ready   out  NUM_REQ      one-hot grant; handshake when valid&ready
//  conv_en     in   1            1: convert a..z to A..Z; 0: pass through unchanged
//  out_valid   out  1            output register holds a byte
//  out_data    out  8            converted byte
//  out_src     out  $clog2(NUM_REQ) index of requester that supplied out_data
//  out_ready   in   1            sink accepts when out_valid&out_ready
//  conv_count  out  CNT_W        bytes actually case-changed (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, out_src=0, conv_count=0,
//    rr_ptr=0, req_ready=0. Reset mid-transfer drops the held byte; no replay.
//  - Slot free = !out_valid | out_ready. req_ready is asserted only when the slot is free,
//    and only to the winner. It is a combinational function of req_valid, rr_ptr, out_valid, and out_ready.
//  - Arbitration: search from rr_ptr upward, wrapping; first asserted req_valid wins.
//    After a grant to k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
//  - Latency: byte handshaken in cycle t appears on out_data/out_valid at t+1.
//    Throughput is 1 byte/cycle while out_ready=1. A simultaneous drain and load is allowed.
//  - out_valid=1 & out_ready=0: out_data/out_src stay stable and all req_ready=0.
//  - Conversion: if conv_en and byte in 8'h61..8'h7A, clear bit 5; else unchanged.
//    8'h60, 8'h7B, and bit7=1 bytes are never changed. conv_en is sampled in the grant cycle.
//  - conv_count increments on each granted byte actually changed and saturates at 2^CNT_W-1.
//  - FSM (output stage): EMPTY --grant--> FULL; FULL --out_ready & !grant--> EMPTY;
//    FULL --out_ready & grant--> FULL (reload); FULL --!out_ready--> FULL.
// CONFIGURATION
//  CASE_CONV_STATS_EN defined: conv_count logic present as above.
//  Not defined: conv_count tied to 0, and no counter flops are inferred.
// STRUCTURE
//  case_conv_pkg: ASCII_LOWER_A=8'h61, ASCII_LOWER_Z=8'h7A, CASE_BIT=5,
//    and the typedef ascii_t (8-bit byte).
//  Sub-module ascii_to_upper: purely combinational (in, en -> out, changed).
//    It is instantiated once, at the mux output.
// TESTING
//  1. Reset: rst_n=0 with req_valid=all 1 -> out_valid=0, req_ready=0, conv_count=0.
//  2. Single req0 sends 8'h61,8'h7A,8'h60,8'h7B with conv_en=1, out_ready=1 ->
//     out_data 8'h41,8'h5A,8'h60,8'h7B; conv_count=2.
//  3. Both requesters valid continuously, out_ready=1 -> grants alternate 0,1,0,1.
//     out_src tracks the grant one cycle later, and no cycle is idle.
//  4. out_ready=0 for 3 cycles while out_valid=1 -> out_data stable, req_ready=0.
//     On release, the same byte drains, then the next winner loads in the same cycle.
//  5. conv_en=0, byte 8'h71 -> out 8'h71 and conv_count unchanged.
//     Byte 8'hE1 with conv_en=1 -> out 8'hE1.
//  6. Async reset asserted while out_valid=1 -> out_valid=0 immediately, rr_ptr=0.
//     With CNT_W=2, 5 conversions leave conv_count=3 (saturation).

Source files
------------

// File: rtl/case_conv_pkg.sv
// Shared types and ASCII constants for the case-conversion arbiter slice.
package case_conv_pkg;

    typedef logic [7:0] ascii_t;

    localparam ascii_t ASCII_LOWER_A = 8'h61;
    localparam ascii_t ASCII_LOWER_Z = 8'h7A;
    localparam int     CASE_BIT      = 5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/case_conv_arbiter_ascii_to_upper.sv
// Combinational lowercase->uppercase converter; flags bytes it actually changed.
module ascii_to_upper
    import case_conv_pkg::*;
(
    input  ascii_t in_byte,
    input  logic   en,
    output ascii_t out_byte,
    output logic   changed
);

    always_comb begin
        changed  = en && (in_byte >= ASCII_LOWER_A) && (in_byte <= ASCII_LOWER_Z);
        out_byte = in_byte;
        if (changed) begin
            out_byte[CASE_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/case_conv_arbiter.sv
// Round-robin arbiter feeding one shared ASCII upper-casing unit and a single output register.
// Optional conversion statistics counter enabled by defining CASE_CONV_STATS_EN.
module case_conv_arbiter
    import case_conv_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int CNT_W   = 16,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   conv_en,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic [SRC_W-1:0]       out_src,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       conv_count
);

    out_state_e       state, state_nxt;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] cand;
    int               sum;
    logic             grant_found;
    logic             slot_free;
    logic             grant_vld;
    ascii_t           sel_byte;
    ascii_t           conv_byte;
    logic             conv_changed;
    logic             vld_p1;
    ascii_t           data_p1;
    logic [SRC_W-1:0] src_p1;

    // Stage 0: round-robin search starting at rr_ptr, then mux and convert the winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = 0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = SRC_W'(sum);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign slot_free = !vld_p1 || out_ready;
    // Gating with rst_n keeps every ready low while the block is held in reset.
    assign grant_vld = rst_n && slot_free && grant_found;

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_byte = req_data[8*int'(grant_idx) +: 8];

    ascii_to_upper u_upper (
        .in_byte  (sel_byte),
        .en       (conv_en),
        .out_byte (conv_byte),
        .changed  (conv_changed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (grant_vld)               state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !grant_vld) state_nxt = ST_EMPTY;
            default:                               state_nxt = ST_EMPTY;
        endcase
    end

    // Stage 1: output register, loaded on every handshake (including drain-and-reload)
    assign vld_p1 = (state == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            src_p1  <= '0;
        end else if (grant_vld) begin
            data_p1 <= conv_byte;
            src_p1  <= grant_idx;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_src   = src_p1;

`ifdef CASE_CONV_STATS_EN
    logic [CNT_W-1:0] cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (grant_vld && conv_changed) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign conv_count = cnt_p1;
`else
    logic unused_conv_changed;
    assign unused_conv_changed = conv_changed;
    assign conv_count = '0;
`endif

endmodule

// File: tb/tb_case_conv_arbiter.sv
// Directed bench for case_conv_arbiter (NUM_REQ=2, CNT_W=2 so saturation is reachable).
module tb_case_conv_arbiter;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 2;
`ifdef CASE_CONV_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 conv_en;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic [0:0]           out_src;
    logic                 out_ready;
    logic [CNT_W-1:0]     conv_count;

    int vecs = 0;
    int errs = 0;

    logic [7:0] t2_in  [4] = '{8'h61, 8'h7A, 8'h60, 8'h7B};
    logic [7:0] t2_exp [4] = '{8'h41, 8'h5A, 8'h60, 8'h7B};
    int g, pg;

    case_conv_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .conv_en    (conv_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int n);
        int m;
        m = (n > 3) ? 3 : n;
        return STATS ? 32'(m) : 32'd0;
    endfunction

    initial begin
        g  = 0;
        pg = 0;
        // Reset with all requesters valid
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_data  = 16'h3130;
        conv_en   = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_conv_count", 32'(conv_count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        // Single requester, conversion boundaries
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 2'b01;
            req_data  = {8'h00, t2_in[i]};
            #1;
            chk("t2_req_ready", 32'(req_ready), 32'd1);
            if (i > 0) begin
                chk("t2_out_valid", 32'(out_valid), 32'd1);
                chk("t2_out_data", 32'(out_data), 32'(t2_exp[i-1]));
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("t2_last_data", 32'(out_data), 32'h7B);
        chk("t2_last_src", 32'(out_src), 32'd0);
        chk("t2_last_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("t2_drained", 32'(out_valid), 32'd0);
        chk("t2_conv_count", 32'(conv_count), cexp(2));

        // Both requesters valid: rr_ptr is 1 after the req0 grants
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 2'b11;
            req_data  = 16'h3130;
            #1;
            g = (i % 2 == 0) ? 1 : 0;
            chk("t3_req_ready", 32'(req_ready), (g == 1) ? 32'd2 : 32'd1);
            if (i > 0) begin
                chk("t3_out_valid", 32'(out_valid), 32'd1);
                chk("t3_out_src", 32'(out_src), 32'(pg));
                chk("t3_out_data", 32'(out_data), 32'h30 + 32'(pg));
            end
            pg = g;
        end

        // Stall for three cycles while holding the src0 byte
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            chk("t4_stall_ready", 32'(req_ready), 32'd0);
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
            chk("t4_stall_data", 32'(out_data), 32'h30);
            chk("t4_stall_src", 32'(out_src), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("t4_release_ready", 32'(req_ready), 32'd2);
        chk("t4_release_data", 32'(out_data), 32'h30);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("t4_reload_valid", 32'(out_valid), 32'd1);
        chk("t4_reload_src", 32'(out_src), 32'd1);
        chk("t4_reload_data", 32'(out_data), 32'h31);
        @(negedge clk);
        #1;
        chk("t4_drained", 32'(out_valid), 32'd0);

        // conv_en=0 passthrough, then a high-bit byte with conv_en=1
        @(negedge clk);
        conv_en   = 1'b0;
        req_valid = 2'b01;
        req_data  = 16'h0071;
        #1;
        chk("t5_ready_a", 32'(req_ready), 32'd1);
        @(negedge clk);
        conv_en  = 1'b1;
        req_data = 16'h00E1;
        #1;
        chk("t5_data_71", 32'(out_data), 32'h71);
        chk("t5_count_a", 32'(conv_count), cexp(2));
        chk("t5_ready_b", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        out_ready = 1'b0;
        #1;
        chk("t5_data_e1", 32'(out_data), 32'hE1);
        chk("t5_valid_e1", 32'(out_valid), 32'd1);
        chk("t5_count_b", 32'(conv_count), cexp(2));

        // Asynchronous reset mid-cycle while holding a byte
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_count", 32'(conv_count), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_valid = 2'b11;
        req_data  = 16'h7A7A;
        #1;
        chk("t6_ptr_reset", 32'(req_ready), 32'd1);

        // Five conversions into a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = (i < 4) ? 2'b11 : 2'b00;
            #1;
            chk("t6_sat_count", 32'(conv_count), cexp(i + 1));
            chk("t6_sat_data", 32'(out_data), 32'h5A);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
